spi_xfer_arbiter: RTL and testbench
===================================

SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the max cycles a granted transfer may spend in LAUNCH+BUSY; used only with SPI_XFER_ARB_TIMEOUT_EN.
REQ-002 clk_i  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 req_i  input  2  SHALL carry per-requester transfer request, held high until done_o of that requester.
REQ-005 lock_i  input  2  SHALL request back-to-back retention of the grant (burst).
REQ-006 wr_i, rd_i  input  2 each  SHALL select write and/or read per requester; both high = full duplex.
REQ-007 tx_byte0_i, tx_byte1_i  input  8 each  SHALL carry each requester's byte to send.
REQ-008 gnt_o  output  2  SHALL be one-hot current owner, zero when no owner.
REQ-009 done_o  output  2  SHALL be a one-cycle completion pulse per requester.
REQ-010 rx_byte_o  output  8  SHALL be the last captured received byte, shared.
REQ-011 err_o  output  1  SHALL be a one-cycle timeout pulse.
REQ-012 host_tx_byte_o  output  8; host_write_o, host_read_o  output  1 each  SHALL drive the SPI host byte interface.
REQ-013 host_idle_i  input  1; host_rx_byte_i  input  8  SHALL be SPI host status and received byte.

Function
REQ-014 FSM states IDLE, LAUNCH, BUSY, DONE SHALL be the only states.
REQ-015 IDLE: when host_idle_i=1 and req_i!=0, owner SHALL be chosen and registered, transition to LAUNCH next cycle; if host_idle_i=0, remain IDLE.
REQ-016 Arbitration SHALL be round-robin on 2 requesters: single requester wins; both requesting, the one not served last wins.
REQ-017 Owner request with wr_i=rd_i=0 SHALL go IDLE->DONE directly, host strobes never asserted, rx_byte_o unchanged.
REQ-018 LAUNCH: host_write_o=wr_i[owner], host_read_o=rd_i[owner], host_tx_byte_o=owner's tx byte; on host_idle_i=0 transition to BUSY.
REQ-019 BUSY: strobes 0, host_tx_byte_o held; on host_idle_i=1 capture host_rx_byte_i into rx_byte_o (only if rd_i[owner]) and go DONE.
REQ-020 DONE: done_o[owner]=1 for exactly one cycle; if lock_i[owner]&req_i[owner] the next transfer SHALL bypass arbitration and go directly to LAUNCH (once host_idle_i=1), else owner cleared, last-served pointer updated, go IDLE.
REQ-021 gnt_o SHALL be asserted from LAUNCH through DONE inclusive, and during lock retention.
REQ-022 Requester deasserting req_i mid-transfer SHALL NOT abort it; done_o still pulses.
REQ-023 Minimum latency req_i rise (host idle) to done_o SHALL be 3 cycles plus host busy time.
REQ-024 host_tx_byte_o SHALL be 0 whenever no owner.

Reset
REQ-025 On rst_ni=0: state IDLE, owner none, gnt_o=0, done_o=0, err_o=0, rx_byte_o=0, host strobes 0, host_tx_byte_o=0, last-served pointer=1 (requester 0 wins first tie), timeout counter 0.
REQ-026 Reset mid-transfer SHALL abandon it with no done_o pulse after release.

Configuration
REQ-027 With SPI_XFER_ARB_TIMEOUT_EN defined, a counter SHALL run in LAUNCH/BUSY; reaching TIMEOUT_CYCLES SHALL drop strobes, pulse err_o and done_o[owner] together, leave rx_byte_o unchanged, release lock, go IDLE.
REQ-028 Without SPI_XFER_ARB_TIMEOUT_EN, no counter SHALL exist, err_o tied 0, FSM waits indefinitely.

Verification
REQ-029 req_i=01, wr=rd=1, tx_byte0=0xA5, host returns 0x3C after 16 busy cycles -> gnt_o=01, host_tx_byte_o=0xA5, done_o=01 once, rx_byte_o=0x3C.
REQ-030 req_i=11 simultaneously, three rounds -> grant order 0,1,0.
REQ-031 Requester 1 lock_i=1 for 3 transfers while requester 0 requests -> requester 1 served 3 times consecutively, then requester 0.
REQ-032 req_i=01 with wr=rd=0 -> done_o=01 one cycle after IDLE, host_write_o/host_read_o never 1.
REQ-033 Macro defined, TIMEOUT_CYCLES=8, host_idle_i stuck 1 -> err_o and done_o pulse at cycle 8 of LAUNCH, FSM IDLE.
REQ-034 rst_ni pulsed low during BUSY -> all outputs reset values, no done_o after release.

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
// Two-requester round-robin arbiter in front of a byte-wide SPI host, with optional lock (burst) retention.
// Define SPI_XFER_ARB_TIMEOUT_EN to abort transfers stuck in LAUNCH/BUSY for TIMEOUT_CYCLES cycles.
module spi_xfer_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    input  logic [1:0] wr_i,
    input  logic [1:0] rd_i,
    input  logic [7:0] tx_byte0_i,
    input  logic [7:0] tx_byte1_i,
    output logic [1:0] gnt_o,
    output logic [1:0] done_o,
    output logic [7:0] rx_byte_o,
    output logic       err_o,
    output logic [7:0] host_tx_byte_o,
    output logic       host_write_o,
    output logic       host_read_o,
    input  logic       host_idle_i,
    input  logic [7:0] host_rx_byte_i
);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_e;

    state_e     state_reg, state_next;
    logic       owner_reg, owner_next;
    logic       owned_reg, owned_next;
    logic       last_reg, last_next;
    logic       wr_reg, wr_next;
    logic       rd_reg, rd_next;
    logic [7:0] tx_reg, tx_next;
    logic [7:0] rx_reg, rx_next;
    logic       timeout;
    logic       start;
    logic       drop_own;
    logic       sel;

`ifdef SPI_XFER_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          in_xfer;

    assign in_xfer  = (state_reg == LAUNCH) || (state_reg == BUSY);
    assign timeout  = in_xfer && (cnt_reg == CW'(TIMEOUT_CYCLES - 1));
    assign cnt_next = (in_xfer && !timeout) ? cnt_reg + 1'b1 : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`else
    // Without the watchdog the FSM waits on the host indefinitely.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        owned_next = owned_reg;
        last_next  = last_reg;
        wr_next    = wr_reg;
        rd_next    = rd_reg;
        tx_next    = tx_reg;
        rx_next    = rx_reg;
        start      = 1'b0;
        drop_own   = 1'b0;
        // Tie goes to the requester not served last.
        sel        = (&req_i) ? ~last_reg : req_i[1];

        unique case (state_reg)
            IDLE: begin
                if (host_idle_i) begin
                    if (owned_reg) begin
                        start = 1'b1;
                        sel   = owner_reg;
                    end else if (|req_i) begin
                        start = 1'b1;
                    end
                end
            end
            LAUNCH: begin
                if (timeout) begin
                    drop_own = 1'b1;
                end else if (!host_idle_i) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (timeout) begin
                    drop_own = 1'b1;
                end else if (host_idle_i) begin
                    if (rd_reg) begin
                        rx_next = host_rx_byte_i;
                    end
                    state_next = DONE;
                end
            end
            DONE: begin
                // Locked owner keeps the grant; it waits in IDLE if the host is not ready yet.
                if (lock_i[owner_reg] && req_i[owner_reg]) begin
                    if (host_idle_i) begin
                        start = 1'b1;
                        sel   = owner_reg;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    drop_own = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (drop_own) begin
            owned_next = 1'b0;
            last_next  = owner_reg;
            state_next = IDLE;
        end
        if (start) begin
            owner_next = sel;
            owned_next = 1'b1;
            wr_next    = wr_i[sel];
            rd_next    = rd_i[sel];
            tx_next    = sel ? tx_byte1_i : tx_byte0_i;
            state_next = (wr_i[sel] || rd_i[sel]) ? LAUNCH : DONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            owned_reg <= 1'b0;
            last_reg  <= 1'b1;
            wr_reg    <= 1'b0;
            rd_reg    <= 1'b0;
            tx_reg    <= 8'h00;
            rx_reg    <= 8'h00;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            owned_reg <= owned_next;
            last_reg  <= last_next;
            wr_reg    <= wr_next;
            rd_reg    <= rd_next;
            tx_reg    <= tx_next;
            rx_reg    <= rx_next;
        end
    end

    assign gnt_o          = owned_reg ? (owner_reg ? 2'b10 : 2'b01) : 2'b00;
    assign done_o         = ((state_reg == DONE) || timeout) ? gnt_o : 2'b00;
    assign err_o          = timeout;
    assign host_write_o   = (state_reg == LAUNCH) && !timeout && wr_reg;
    assign host_read_o    = (state_reg == LAUNCH) && !timeout && rd_reg;
    assign host_tx_byte_o = owned_reg ? tx_reg : 8'h00;
    assign rx_byte_o      = rx_reg;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: directed scenarios plus random traffic against a transaction-level model
// of the arbitration, lock and byte-capture rules, with a behavioural SPI host.
module tb_spi_xfer_arbiter;

`ifdef SPI_XFER_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [1:0] req_i = '0, lock_i = '0, wr_i = '0, rd_i = '0;
    logic [7:0] tx_byte0_i = '0, tx_byte1_i = '0;
    logic [1:0] gnt_o, done_o;
    logic [7:0] rx_byte_o, host_tx_byte_o;
    logic       err_o, host_write_o, host_read_o;
    logic       host_idle_i = 1'b1;
    logic [7:0] host_rx_byte_i = '0;

    spi_xfer_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .lock_i(lock_i), .wr_i(wr_i), .rd_i(rd_i),
        .tx_byte0_i(tx_byte0_i), .tx_byte1_i(tx_byte1_i), .gnt_o(gnt_o), .done_o(done_o),
        .rx_byte_o(rx_byte_o), .err_o(err_o), .host_tx_byte_o(host_tx_byte_o),
        .host_write_o(host_write_o), .host_read_o(host_read_o),
        .host_idle_i(host_idle_i), .host_rx_byte_i(host_rx_byte_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0, n_fail = 0;
    // Reference model state
    bit         active_m, arb_due;
    int         owner_m, last_m;
    logic [7:0] rx_m;
    int         served_q[$];
    int         burst_left[2], auto_cnt[2], start_cyc[2];
    bit         p_wr[2], p_rd[2];
    logic [7:0] p_tx[2];
    int         p_burst[2];
    bit         rand_en;
    int         cyc, last_lat, strobe_cnt;
    // Behavioural host
    int         host_cnt, fixed_len;
    bit         host_deaf, use_fixed, pend_rd;
    logic [7:0] fixed_rx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic load(input int i, input bit w, input bit r, input logic [7:0] t, input bit lk);
        req_i[i]  = 1'b1;
        wr_i[i]   = w;
        rd_i[i]   = r;
        lock_i[i] = lk;
        if (i == 0) tx_byte0_i = t;
        else        tx_byte1_i = t;
        start_cyc[i] = cyc;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_rx", 32'(rx_byte_o), 0);
        check("rst_tx", 32'(host_tx_byte_o), 0);
        check("rst_strobe", 32'({host_write_o, host_read_o}), 0);
        req_i = '0; lock_i = '0; wr_i = '0; rd_i = '0; tx_byte0_i = '0; tx_byte1_i = '0;
        host_idle_i = 1'b1; host_cnt = 0; host_deaf = 0; pend_rd = 0;
        active_m = 0; arb_due = 0; last_m = 1; rx_m = 8'h00; served_q.delete();
        for (int i = 0; i < 2; i++) begin
            burst_left[i] = 0;
            auto_cnt[i]   = 0;
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic step();
        int         win, o;
        bit         released, retain;
        logic [1:0] dropped;
        @(posedge clk_i);
        #1;
        cyc++;
        released = 0;
        dropped  = 2'b00;
        // Ownership: a grant may only appear after an arbitration opportunity.
        if (!active_m) begin
            if (arb_due) begin
                win = (req_i == 2'b11) ? 1 - last_m : (req_i[1] ? 1 : 0);
                check("arb_gnt", 32'(gnt_o), 32'(1 << win));
                active_m = 1;
                owner_m  = win;
            end else begin
                check("no_gnt", 32'(gnt_o), 0);
            end
        end else begin
            check("gnt_hold", 32'(gnt_o), 32'(1 << owner_m));
        end
        if (gnt_o == 2'b00) begin
            check("idle_tx", 32'(host_tx_byte_o), 0);
            check("idle_strobe", 32'({host_write_o, host_read_o}), 0);
        end
        // Completion (normal or timeout)
        if (done_o != 2'b00 || err_o) begin
            o = owner_m;
            check("done_owner", 32'(done_o), active_m ? 32'(1 << o) : 32'(0));
            check("err_o", 32'(err_o), 32'(host_deaf));
            check("rx_byte", 32'(rx_byte_o), 32'(rx_m));
            last_lat = cyc - start_cyc[o];
            served_q.push_back(o);
            $display("[TB] xfer owner=%0d rx=%02h err=%0d latency=%0d", o, rx_byte_o, err_o, last_lat);
            if (burst_left[o] > 1) begin
                burst_left[o]--;
                load(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
            end else begin
                req_i[o] = 1'b0; lock_i[o] = 1'b0; burst_left[o] = 0; dropped[o] = 1'b1;
            end
            retain = lock_i[o] && req_i[o] && !err_o;
            if (!retain) begin
                active_m = 0;
                last_m   = o;
                released = 1;
            end
        end
        // Host: one busy period per strobe, returns a byte when it goes idle again.
        if (host_cnt > 0) begin
            check("busy_strobe", 32'({host_write_o, host_read_o}), 0);
            host_cnt--;
            if (host_cnt == 0) begin
                host_idle_i    = 1'b1;
                host_rx_byte_i = use_fixed ? fixed_rx : 8'($urandom);
                if (pend_rd) rx_m = host_rx_byte_i;
            end
        end else if (host_idle_i && (host_write_o || host_read_o) && !host_deaf) begin
            check("host_tx", 32'(host_tx_byte_o), 32'(owner_m ? tx_byte1_i : tx_byte0_i));
            check("host_wr", 32'(host_write_o), 32'(wr_i[owner_m]));
            check("host_rd", 32'(host_read_o), 32'(rd_i[owner_m]));
            pend_rd     = rd_i[owner_m];
            host_idle_i = 1'b0;
            host_cnt    = (fixed_len > 0) ? fixed_len : $urandom_range(1, 5);
            strobe_cnt++;
        end
        // New requests
        for (int i = 0; i < 2; i++) begin
            if (!req_i[i] && !dropped[i]) begin
                if (auto_cnt[i] > 0) begin
                    auto_cnt[i]--;
                    burst_left[i] = p_burst[i];
                    load(i, p_wr[i], p_rd[i], p_tx[i], p_burst[i] > 1);
                end else if (rand_en && $urandom_range(0, 3) == 0) begin
                    burst_left[i] = $urandom_range(1, 3);
                    load(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                         burst_left[i] > 1);
                end
            end
        end
        arb_due = !active_m && !released && (req_i != 2'b00) && host_idle_i;
    endtask

    task automatic wait_served(input string tag, input int n);
        int k = 0;
        while (served_q.size() < n && k < 400) begin
            step();
            k++;
        end
        check(tag, 32'(served_q.size()), 32'(n));
    endtask

    task automatic set_p(input int i, input bit w, input bit r, input logic [7:0] t, input int b);
        p_wr[i] = w; p_rd[i] = r; p_tx[i] = t; p_burst[i] = b;
    endtask

    initial begin
        int k, s0;
        cyc = 0; strobe_cnt = 0; rand_en = 0; fixed_len = 0; use_fixed = 0; fixed_rx = 8'h00;
        do_reset();

        // Single full-duplex transfer, 16 host busy cycles
        fixed_len = 16; use_fixed = 1; fixed_rx = 8'h3C;
        set_p(0, 1, 1, 8'hA5, 1);
        auto_cnt[0] = 1;
        wait_served("single_xfer", 1);
        check("single_rx", 32'(rx_byte_o), 32'h3C);
        repeat (5) step();
        check("single_once", 32'(served_q.size()), 1);

        // No-op transfer: straight to DONE, host never strobed
        s0 = strobe_cnt;
        set_p(0, 0, 0, 8'h11, 1);
        auto_cnt[0] = 1;
        wait_served("noop_xfer", 2);
        check("noop_lat", 32'(last_lat), 1);
        check("noop_strobes", 32'(strobe_cnt), 32'(s0));
        check("noop_rx", 32'(rx_byte_o), 32'h3C);

        // Reset while the host is busy
        fixed_len = 20;
        set_p(0, 1, 1, 8'h5A, 1);
        auto_cnt[0] = 1;
        k = 0;
        while (host_cnt == 0 && k < 50) begin step(); k++; end
        check("busy_reached", 32'(host_cnt > 0), 1);
        repeat (3) step();
        do_reset();
        repeat (10) step();
        check("no_done_after_rst", 32'(served_q.size()), 0);

        // Simultaneous requests: round-robin order 0,1,0
        do_reset();
        fixed_len = 2;
        set_p(0, 1, 0, 8'h01, 1);
        set_p(1, 1, 0, 8'h02, 1);
        auto_cnt[0] = 2; auto_cnt[1] = 1;
        wait_served("rr_rounds", 3);
        check("rr_0", 32'(served_q[0]), 0);
        check("rr_1", 32'(served_q[1]), 1);
        check("rr_2", 32'(served_q[2]), 0);

        // Locked burst of three on requester 1 while requester 0 waits
        served_q.delete();
        set_p(1, 1, 1, 8'hC3, 3);
        set_p(0, 0, 1, 8'h77, 1);
        auto_cnt[1] = 1;
        step();
        auto_cnt[0] = 1;
        wait_served("lock_burst", 4);
        check("lock_0", 32'(served_q[0]), 1);
        check("lock_1", 32'(served_q[1]), 1);
        check("lock_2", 32'(served_q[2]), 1);
        check("lock_3", 32'(served_q[3]), 0);

`ifdef SPI_XFER_ARB_TIMEOUT_EN
        // Host stuck idle: watchdog fires on the TO-th LAUNCH cycle
        do_reset();
        host_deaf = 1;
        set_p(0, 1, 0, 8'h99, 1);
        auto_cnt[0] = 1;
        wait_served("timeout_xfer", 1);
        check("timeout_lat", 32'(last_lat), TO);
        step();
        host_deaf = 0;
        check("timeout_idle", 32'(gnt_o), 0);
`endif

        // Random traffic
        do_reset();
        fixed_len = 0; use_fixed = 0; rand_en = 1;
        repeat (3000) step();
        rand_en = 0;
        k = 0;
        while ((req_i != 2'b00 || active_m) && k < 400) begin step(); k++; end
        check("drain_req", 32'(req_i), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
